// File: rtl/osiris_pkg.sv
// Shared types and constants for the Osiris I hazard/forwarding logic.
package osiris_pkg;

    // Operand mux select encoding, matching the existing 3:1 EX operand mux.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_e;

    // Register-usage shadow of the EX stage.
    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       st;
    } ex_slot_t;

    // Register-usage shadow of the MEM stage.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       st;
    } mem_slot_t;

    // Register-usage shadow of the WB stage.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
    } wb_slot_t;

    // A bubble carries all-zero register fields so it never matches anything.
    localparam ex_slot_t EX_BUBBLE = '0;

endpackage

// File: rtl/forward_sel.sv
// Forwarding select for one EX operand: MEM ALU result beats WB result beats regfile.
module forward_sel
    import osiris_pkg::*;
(
    input  logic [4:0] ex_rs_i,
    input  logic       mem_valid_i,
    input  logic       mem_we_i,
    input  logic       mem_ld_i,
    input  logic [4:0] mem_rd_i,
    input  logic       wb_valid_i,
    input  logic       wb_we_i,
    input  logic [4:0] wb_rd_i,
    output logic [1:0] sel_o
);

    logic mem_hit_s;
    logic wb_hit_s;

    // Match producers against the operand; a load in MEM has no data yet, x0 never forwards.
    always_comb begin
        mem_hit_s = mem_valid_i & mem_we_i & ~mem_ld_i &
                    (mem_rd_i != 5'd0) & (mem_rd_i == ex_rs_i);
        wb_hit_s  = wb_valid_i & wb_we_i &
                    (wb_rd_i != 5'd0) & (wb_rd_i == ex_rs_i);
        if (mem_hit_s) begin
            sel_o = FWD_MEM;
        end else if (wb_hit_s) begin
            sel_o = FWD_WB;
        end else begin
            sel_o = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection, operand forwarding and pipeline stall/flush/freeze control
// for the Osiris I five-stage RV32I core.
module hazard_forward_unit
    import osiris_pkg::*;
#(
    parameter int WAIT_MAX = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic [4:0] i_id_rd,
    input  logic       i_id_reg_write,
    input  logic       i_id_mem_read,
    input  logic       i_id_mem_write,
    input  logic       i_branch_taken,
    input  logic       i_dmem_ready,
    output logic [1:0] o_fwd_a,
    output logic [1:0] o_fwd_b,
    output logic       o_stall_if,
    output logic       o_stall_id,
    output logic       o_flush_id,
    output logic       o_flush_ex,
    output logic       o_freeze,
    output logic       o_mem_timeout
);

    localparam int            CW      = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_MAX);
    localparam logic [CW-1:0] CNT_PRE = CW'(WAIT_MAX - 1);

    ex_slot_t      ex_q,  ex_d;
    mem_slot_t     mem_q, mem_d;
    wb_slot_t      wb_q,  wb_d;
    hz_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic       mem_busy_s;
    logic       load_use_s;
    logic       flush_id_s;
    logic       flush_ex_s;
    logic       stall_s;
    logic       timeout_s;
    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;

    forward_sel u_fwd_a (
        .ex_rs_i     (ex_q.rs1),
        .mem_valid_i (mem_q.valid),
        .mem_we_i    (mem_q.we),
        .mem_ld_i    (mem_q.ld),
        .mem_rd_i    (mem_q.rd),
        .wb_valid_i  (wb_q.valid),
        .wb_we_i     (wb_q.we),
        .wb_rd_i     (wb_q.rd),
        .sel_o       (fwd_a_s)
    );

    forward_sel u_fwd_b (
        .ex_rs_i     (ex_q.rs2),
        .mem_valid_i (mem_q.valid),
        .mem_we_i    (mem_q.we),
        .mem_ld_i    (mem_q.ld),
        .mem_rd_i    (mem_q.rd),
        .wb_valid_i  (wb_q.valid),
        .wb_we_i     (wb_q.we),
        .wb_rd_i     (wb_q.rd),
        .sel_o       (fwd_b_s)
    );

    // Hazard conditions, resolved in priority order freeze > branch flush > load-use stall.
    always_comb begin
        mem_busy_s = mem_q.valid & (mem_q.ld | mem_q.st) & ~i_dmem_ready;
        load_use_s = ex_q.valid & ex_q.ld & ex_q.we & (ex_q.rd != 5'd0) & i_id_valid &
                     ((ex_q.rd == i_id_rs1) | (ex_q.rd == i_id_rs2));
        flush_id_s = ~mem_busy_s & i_branch_taken;
        flush_ex_s = ~mem_busy_s & (i_branch_taken | load_use_s);
        stall_s    = ~mem_busy_s & ~i_branch_taken & load_use_s;
    end

    // Shadow slot advance: hold everything while frozen, otherwise shift and inject ID or a bubble.
    always_comb begin
        if (mem_busy_s) begin
            ex_d  = ex_q;
            mem_d = mem_q;
            wb_d  = wb_q;
        end else begin
            wb_d.valid  = mem_q.valid;
            wb_d.rd     = mem_q.rd;
            wb_d.we     = mem_q.we;
            mem_d.valid = ex_q.valid;
            mem_d.rd    = ex_q.rd;
            mem_d.we    = ex_q.we;
            mem_d.ld    = ex_q.ld;
            mem_d.st    = ex_q.st;
            if (flush_ex_s || !i_id_valid) begin
                ex_d = EX_BUBBLE;
            end else begin
                ex_d.valid = 1'b1;
                ex_d.rs1   = i_id_rs1;
                ex_d.rs2   = i_id_rs2;
                ex_d.rd    = i_id_rd;
                ex_d.we    = i_id_reg_write;
                ex_d.ld    = i_id_mem_read;
                ex_d.st    = i_id_mem_write;
            end
        end
    end

    // Memory-wait FSM next state.
    always_comb begin
        case (state_q)
            ST_RUN:      state_d = mem_busy_s   ? ST_MEM_WAIT : ST_RUN;
            ST_MEM_WAIT: state_d = i_dmem_ready ? ST_RUN      : ST_MEM_WAIT;
            default:     state_d = ST_RUN;
        endcase
    end

    // Wait counter: zero in RUN, counts MEM_WAIT cycles and sticks at WAIT_MAX.
    always_comb begin
        case (state_q)
            ST_RUN:      cnt_d = {CW{1'b0}};
            ST_MEM_WAIT: cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + {{(CW-1){1'b0}}, 1'b1};
            default:     cnt_d = {CW{1'b0}};
        endcase
    end

    // State register for the shadow slots, FSM and wait counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_q    <= EX_BUBBLE;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= ST_RUN;
            cnt_q   <= {CW{1'b0}};
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Control outputs; the timeout fires on the wait cycle that brings the count to WAIT_MAX.
    always_comb begin
        timeout_s = (state_q == ST_MEM_WAIT) & mem_busy_s & (cnt_q == CNT_PRE);
        if (i_rst) begin
            o_fwd_a       = FWD_RF;
            o_fwd_b       = FWD_RF;
            o_stall_if    = 1'b0;
            o_stall_id    = 1'b0;
            o_flush_id    = 1'b0;
            o_flush_ex    = 1'b0;
            o_freeze      = 1'b0;
            o_mem_timeout = 1'b0;
        end else begin
            o_fwd_a       = fwd_a_s;
            o_fwd_b       = fwd_b_s;
            o_stall_if    = stall_s;
            o_stall_id    = stall_s;
            o_flush_id    = flush_id_s;
            o_flush_ex    = flush_ex_s;
            o_freeze      = mem_busy_s;
            o_mem_timeout = timeout_s;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Randomized and directed bench for hazard_forward_unit against a stage-list reference model.
module tb_hazard_forward_unit;

    localparam int WM = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_we, id_ld, id_st;
    logic       br, rdy;
    logic [1:0] fwd_a, fwd_b;
    logic       stall_if, stall_id, flush_id, flush_ex, freeze, timeout;

    always #5 clk = ~clk;

    hazard_forward_unit #(.WAIT_MAX(WM)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_id_valid     (id_valid),
        .i_id_rs1       (id_rs1),
        .i_id_rs2       (id_rs2),
        .i_id_rd        (id_rd),
        .i_id_reg_write (id_we),
        .i_id_mem_read  (id_ld),
        .i_id_mem_write (id_st),
        .i_branch_taken (br),
        .i_dmem_ready   (rdy),
        .o_fwd_a        (fwd_a),
        .o_fwd_b        (fwd_b),
        .o_stall_if     (stall_if),
        .o_stall_id     (stall_id),
        .o_flush_id     (flush_id),
        .o_flush_ex     (flush_ex),
        .o_freeze       (freeze),
        .o_mem_timeout  (timeout)
    );

    // Reference model: list of in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
    typedef struct {
        bit v;
        int rs1;
        int rs2;
        int rd;
        bit we;
        bit ld;
        bit st;
    } instr_t;

    instr_t pipe[3];
    instr_t nop;
    int     frozen_run;   // consecutive frozen cycles before the current one
    int     n_cmp = 0;
    int     n_err = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_fwd(input int rs);
        if (pipe[1].v && pipe[1].we && !pipe[1].ld && pipe[1].rd != 0 && pipe[1].rd == rs) return 2;
        if (pipe[2].v && pipe[2].we && pipe[2].rd != 0 && pipe[2].rd == rs) return 1;
        return 0;
    endfunction

    // One clock cycle: drive, check every output against the model, then advance the model.
    task automatic step(input bit v, input int r1, input int r2, input int rd,
                        input bit we, input bit ld, input bit st,
                        input bit b, input bit ready, input bit reset);
        bit frz, lu;
        int run;
        instr_t cur;
        rst = reset; id_valid = v;
        id_rs1 = 5'(r1); id_rs2 = 5'(r2); id_rd = 5'(rd);
        id_we = we; id_ld = ld; id_st = st; br = b; rdy = ready;
        #1;
        frz = pipe[1].v && (pipe[1].ld || pipe[1].st) && !ready;
        lu  = pipe[0].v && pipe[0].ld && pipe[0].we && pipe[0].rd != 0 && v &&
              (pipe[0].rd == r1 || pipe[0].rd == r2);
        run = frz ? frozen_run + 1 : 0;
        check_eq("fwd_a",    int'(fwd_a),    reset ? 0 : model_fwd(pipe[0].rs1));
        check_eq("fwd_b",    int'(fwd_b),    reset ? 0 : model_fwd(pipe[0].rs2));
        check_eq("stall_if", int'(stall_if), int'(!reset && !frz && !b && lu));
        check_eq("stall_id", int'(stall_id), int'(!reset && !frz && !b && lu));
        check_eq("flush_id", int'(flush_id), int'(!reset && !frz && b));
        check_eq("flush_ex", int'(flush_ex), int'(!reset && !frz && (b || lu)));
        check_eq("freeze",   int'(freeze),   int'(!reset && frz));
        check_eq("timeout",  int'(timeout),  int'(!reset && run == WM + 1));
        @(posedge clk);
        if (reset) begin
            pipe[0] = nop; pipe[1] = nop; pipe[2] = nop;
            frozen_run = 0;
        end else begin
            frozen_run = run;
            if (!frz) begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                if (!v || b || lu) begin
                    pipe[0] = nop;
                end else begin
                    cur = '{v: 1'b1, rs1: r1, rs2: r2, rd: rd, we: we, ld: ld, st: st};
                    pipe[0] = cur;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input bit ready);
        step(0, 0, 0, 0, 0, 0, 0, 0, ready, 0);
    endtask

    initial begin
        int burst;
        nop = '{v: 1'b0, rs1: 0, rs2: 0, rd: 0, we: 1'b0, ld: 1'b0, st: 1'b0};
        pipe[0] = nop; pipe[1] = nop; pipe[2] = nop;
        frozen_run = 0;
        @(negedge clk);

        // Reset, then a quiet cycle with everything at zero.
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);

        // add x5; sub x6,x5,x1; second consumer of x5 (MEM then WB forwarding).
        step(1, 1, 2, 5, 1, 0, 0, 0, 1, 0);
        step(1, 5, 1, 6, 1, 0, 0, 0, 1, 0);
        step(1, 5, 3, 8, 1, 0, 0, 0, 1, 0);
        idle(1); idle(1);

        // x7 written twice, consumer on rs2: MEM wins; then the same with x0.
        step(1, 1, 2, 7, 1, 0, 0, 0, 1, 0);
        step(1, 1, 2, 7, 1, 0, 0, 0, 1, 0);
        step(1, 1, 7, 9, 1, 0, 0, 0, 1, 0);
        step(1, 1, 2, 0, 1, 0, 0, 0, 1, 0);
        step(1, 1, 2, 0, 1, 0, 0, 0, 1, 0);
        step(1, 1, 0, 9, 1, 0, 0, 0, 1, 0);
        idle(1); idle(1);

        // lw x3 followed by a use of x3 on rs2; ID holds the consumer for the stall cycle.
        step(1, 1, 0, 3, 1, 1, 0, 0, 1, 0);
        step(1, 4, 3, 10, 1, 0, 0, 0, 1, 0);
        step(1, 4, 3, 10, 1, 0, 0, 0, 1, 0);
        idle(1); idle(1);

        // Load-use together with a taken branch: branch wins.
        step(1, 1, 0, 3, 1, 1, 0, 0, 1, 0);
        step(1, 3, 2, 11, 1, 0, 0, 1, 1, 0);
        idle(1); idle(1);

        // Store stuck in MEM for three cycles, with a branch held during the wait.
        step(1, 1, 2, 0, 0, 0, 1, 0, 1, 0);
        step(1, 5, 6, 12, 1, 0, 0, 0, 1, 0);
        step(1, 7, 8, 13, 1, 0, 0, 1, 0, 0);
        step(1, 7, 8, 13, 1, 0, 0, 1, 0, 0);
        step(1, 7, 8, 13, 1, 0, 0, 1, 0, 0);
        step(1, 7, 8, 13, 1, 0, 0, 1, 1, 0);
        idle(1); idle(1);

        // Load stuck for six cycles: one timeout pulse, then reset mid-wait.
        step(1, 1, 2, 4, 1, 1, 0, 0, 1, 0);
        idle(1);
        for (int i = 0; i < 6; i++) idle(0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(0); idle(1);

        // Randomized traffic with small register numbers and bursts of memory wait.
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            bit ready;
            int kind;
            if (burst == 0 && $urandom_range(0, 9) == 0) burst = $urandom_range(1, 7);
            ready = (burst == 0);
            if (burst > 0) burst--;
            kind = $urandom_range(0, 3);
            step($urandom_range(0, 7) != 0,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3) != 0, kind == 1, kind == 2,
                 $urandom_range(0, 11) == 0, ready,
                 $urandom_range(0, 199) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
